// File: rtl/fib_age_arbiter.sv
`default_nettype none
// ==========================================================================
// fib_age_arbiter : shares the FIB table port between lookup and age sweep
// Rev 1.0
// ==========================================================================
module fib_age_arbiter #(
  parameter int FIB_ASZ      = 8,
  parameter int AGE_SZ       = 3,
  parameter int PORT_SZ      = 2,
  parameter int AGE_INTERVAL = 1000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            age_en,
  input  logic                            lk_rd_n,
  input  logic                            lk_wr_n,
  input  logic [FIB_ASZ-1:0]              lk_addr,
  input  logic [48+AGE_SZ+PORT_SZ-1:0]    lk_wdata,
  output logic [48+AGE_SZ+PORT_SZ-1:0]    lk_rdata,
  output logic                            lk_gnt,
  output logic                            ft_rd_n,
  output logic                            ft_wr_n,
  output logic [FIB_ASZ-1:0]              ft_addr,
  output logic [48+AGE_SZ+PORT_SZ-1:0]    ft_wdata,
  input  logic [48+AGE_SZ+PORT_SZ-1:0]    ft_rdata,
  output logic                            sweep_busy,
  output logic                            sweep_done,
  output logic                            age_overrun
);

  localparam int ENTRY_SZ = 48 + AGE_SZ + PORT_SZ;
  localparam int CNT_W    = (AGE_INTERVAL > 1) ? $clog2(AGE_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(AGE_INTERVAL - 1);
  localparam logic [FIB_ASZ-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [FIB_ASZ-1:0]   age_addr_q;
  logic                 sweep_pend_q;
  logic                 sweep_done_q;
  logic                 age_overrun_q;

  logic                 tick;
  logic                 lk_req;
  logic [AGE_SZ-1:0]    cur_age;
  logic [AGE_SZ-1:0]    dec_age;

  assign tick    = age_en && (cnt_q == CNT_LAST);
  assign cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign lk_req  = !lk_rd_n || !lk_wr_n;
  assign cur_age = ft_rdata[PORT_SZ +: AGE_SZ];
  assign dec_age = cur_age - 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      age_addr_q    <= '0;
      sweep_pend_q  <= 1'b0;
      sweep_done_q  <= 1'b0;
      age_overrun_q <= 1'b0;
    end else begin
      sweep_done_q  <= 1'b0;
      // A tick that lands while a sweep is running is dropped, not queued.
      age_overrun_q <= tick && (state_q != S_IDLE);
      if (age_en) begin
        cnt_q <= cnt_d;
      end
      case (state_q)
        S_IDLE: begin
          if (sweep_pend_q) begin
            sweep_pend_q <= 1'b0;
            age_addr_q   <= '0;
            state_q      <= S_RD;
          end
          if (tick) begin
            sweep_pend_q <= 1'b1;
          end
        end
        S_RD: begin
          if (!lk_req) begin
            state_q <= S_WR;
          end
        end
        S_WR: begin
          if (age_addr_q == ADDR_LAST) begin
            sweep_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            age_addr_q <= age_addr_q + 1'b1;
            state_q    <= S_RD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    lk_gnt   = 1'b1;
    ft_rd_n  = lk_rd_n;
    ft_wr_n  = lk_wr_n;
    ft_addr  = lk_addr;
    ft_wdata = lk_wdata;
    case (state_q)
      S_RD: begin
        if (!lk_req) begin
          ft_rd_n = 1'b0;
          ft_wr_n = 1'b1;
          ft_addr = age_addr_q;
        end
      end
      S_WR: begin
        // Write-back half of the pair; an already-expired entry is left alone.
        lk_gnt   = 1'b0;
        ft_rd_n  = 1'b1;
        ft_wr_n  = (cur_age == '0);
        ft_addr  = age_addr_q;
        ft_wdata = {ft_rdata[ENTRY_SZ-1:AGE_SZ+PORT_SZ], dec_age, ft_rdata[PORT_SZ-1:0]};
      end
      default: ;
    endcase
  end

  assign lk_rdata    = ft_rdata;
  assign sweep_busy  = (state_q != S_IDLE);
  assign sweep_done  = sweep_done_q;
  assign age_overrun = age_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_age_arbiter.sv
`default_nettype none
// tb_fib_age_arbiter : random lookup traffic and aging sweeps checked
// against a table-level reference model through an expectation scoreboard.
module tb_fib_age_arbiter;

  localparam int FA = 3;
  localparam int AS = 3;
  localparam int PS = 2;
  localparam int AI = 12;
  localparam int N  = 1 << FA;
  localparam int ES = 48 + AS + PS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          age_en = 1'b0;
  logic          lk_rd_n = 1'b1;
  logic          lk_wr_n = 1'b1;
  logic [FA-1:0] lk_addr = '0;
  logic [ES-1:0] lk_wdata = '0;
  logic [ES-1:0] lk_rdata;
  logic          lk_gnt;
  logic          ft_rd_n;
  logic          ft_wr_n;
  logic [FA-1:0] ft_addr;
  logic [ES-1:0] ft_wdata;
  logic [ES-1:0] ft_rdata;
  logic          sweep_busy;
  logic          sweep_done;
  logic          age_overrun;

  always #5 clk = ~clk;

  fib_age_arbiter #(
    .FIB_ASZ(FA), .AGE_SZ(AS), .PORT_SZ(PS), .AGE_INTERVAL(AI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .age_en(age_en),
    .lk_rd_n(lk_rd_n), .lk_wr_n(lk_wr_n), .lk_addr(lk_addr), .lk_wdata(lk_wdata),
    .lk_rdata(lk_rdata), .lk_gnt(lk_gnt),
    .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_addr(ft_addr), .ft_wdata(ft_wdata),
    .ft_rdata(ft_rdata),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .age_overrun(age_overrun)
  );

  // Table RAM attached to the arbiter's table port (environment, not the model).
  logic [ES-1:0] ram      [N];
  logic [ES-1:0] init_mem [N];
  logic [ES-1:0] ram_q = '0;
  logic          load = 1'b0;
  assign ft_rdata = ram_q;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) ram[i] <= init_mem[i];
    end else begin
      if (!ft_wr_n) ram[ft_addr] <= ft_wdata;
    end
    if (!ft_rd_n) ram_q <= ram[ft_addr];
  end

  typedef struct packed {
    logic          gnt, busy, rd_n, wr_n, done, ovr;
    logic [FA-1:0] addr;
    logic [ES-1:0] wdata;
  } exp_t;

  exp_t          expq[$];
  logic [ES-1:0] rdq[$];
  int            total = 0;
  int            bad = 0;
  int            done_seen = 0;

  // Reference model: table contents plus sweep progress as a position
  // 0..2N-1 (even = aging read of entry pos/2, odd = its write-back).
  logic [ES-1:0] mem [N];
  int            m_cnt, m_pos;
  bit            m_pend, m_act, m_done, m_ovr;
  bit            last_gnt = 1'b1;
  bit            cur_rd, cur_wr;
  int            cur_a;
  logic [ES-1:0] cur_d;

  function automatic int age_of(input logic [ES-1:0] e);
    return int'(e[PS +: AS]);
  endfunction

  function automatic logic [ES-1:0] aged(input logic [ES-1:0] e);
    logic [ES-1:0] r;
    r = e;
    r[PS +: AS] = AS'(age_of(e) - 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit rd, input bit wr, input int a, input logic [ES-1:0] d,
                      input bit en, input bit rst_low);
    exp_t e;
    bit   req, wrph, tick;
    int   ea;
    @(posedge clk);
    #1;
    reset_n  = !rst_low;
    age_en   = en;
    lk_rd_n  = !rd;
    lk_wr_n  = !wr;
    lk_addr  = a[FA-1:0];
    lk_wdata = d;
    if (rst_low) begin
      m_cnt = 0; m_pos = 0; m_pend = 0; m_act = 0; m_done = 0; m_ovr = 0;
    end
    req  = rd || wr;
    wrph = m_act && (m_pos % 2 == 1);
    ea   = m_pos / 2;
    e.gnt = !wrph; e.busy = m_act; e.done = m_done; e.ovr = m_ovr;
    e.rd_n = !rd; e.wr_n = !wr; e.addr = a[FA-1:0]; e.wdata = d;
    if (wrph) begin
      e.rd_n = 1'b1;
      e.wr_n = (age_of(mem[ea]) == 0);
      e.addr = ea[FA-1:0];
      e.wdata = aged(mem[ea]);
    end else if (m_act && !req) begin
      e.rd_n = 1'b0;
      e.wr_n = 1'b1;
      e.addr = ea[FA-1:0];
    end
    expq.push_back(e);
    last_gnt = e.gnt;
    if (rst_low) return;
    if (!wrph && rd) rdq.push_back(mem[a]);
    if (wrph && age_of(mem[ea]) != 0) mem[ea] = aged(mem[ea]);
    if (!wrph && wr) mem[a] = d;
    tick = en && (m_cnt == AI - 1);
    if (en) m_cnt = (m_cnt == AI - 1) ? 0 : m_cnt + 1;
    m_done = wrph && (ea == N - 1);
    m_ovr  = tick && m_act;
    if (m_act) begin
      if (wrph) begin
        if (ea == N - 1) m_act = 0;
        else m_pos++;
      end else if (!req) begin
        m_pos++;
      end
    end else begin
      if (m_pend) begin m_act = 1; m_pos = 0; m_pend = 0; end
      if (tick) m_pend = 1;
    end
  endtask

  // A lookup refused by the arbiter is re-presented unchanged.
  task automatic rstep(input bit en);
    int r;
    logic [63:0] tmp;
    if (last_gnt) begin
      r = $urandom_range(99);
      cur_rd = (r < 30);
      cur_wr = (r >= 30 && r < 45);
      cur_a  = $urandom_range(N - 1);
      tmp    = {$urandom(), $urandom()};
      cur_d  = tmp[ES-1:0];
    end
    step(cur_rd, cur_wr, cur_a, cur_d, en, 1'b0);
  endtask

  // Monitor: pops one expectation per cycle, plus read data one cycle after a granted read.
  initial begin
    exp_t e;
    bit   p_rd;
    p_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (sweep_done) done_seen++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ctl{gnt,busy,rd_n,wr_n,done,ovr}",
            64'({lk_gnt, sweep_busy, ft_rd_n, ft_wr_n, sweep_done, age_overrun}),
            64'({e.gnt, e.busy, e.rd_n, e.wr_n, e.done, e.ovr}));
        if (!e.rd_n || !e.wr_n) chk("ft_addr", 64'(ft_addr), 64'(e.addr));
        if (!e.wr_n) chk("ft_wdata", 64'(ft_wdata), 64'(e.wdata));
      end
      if (p_rd) begin
        if (rdq.size() == 0) begin
          chk("rdata_unexpected", 64'(lk_rdata), 64'(0));
        end else begin
          chk("lk_rdata", 64'(lk_rdata), 64'(rdq.pop_front()));
        end
      end
      p_rd = reset_n && lk_gnt && !lk_rd_n;
    end
  end

  initial begin
    logic [63:0]   tmp;
    logic [ES-1:0] want;
    for (int i = 0; i < N; i++) begin
      tmp = {$urandom(), $urandom()};
      init_mem[i] = tmp[ES-1:0];
      init_mem[i][PS +: AS] = (i == 1) ? AS'(0) : AS'(3);
      mem[i] = init_mem[i];
    end
    load = 1'b1;
    step(0, 0, 0, '0, 0, 1);
    load = 1'b0;
    step(0, 0, 0, '0, 0, 1);

    // One sweep with no traffic: every entry ages from 3 to 2, entry 1 stays expired.
    for (int k = 0; k < AI; k++) step(0, 0, 0, '0, 1, 0);
    for (int k = 0; k < 2 * N + 6; k++) step(0, 0, 0, '0, 0, 0);
    @(negedge clk);
    #1;
    chk("sweepA_done_count", 64'(done_seen), 64'(1));
    for (int i = 0; i < N; i++) begin
      want = init_mem[i];
      if (i != 1) want[PS +: AS] = AS'(2);
      chk("sweepA_entry", 64'(ram[i]), 64'(want));
    end

    // Random lookup traffic with the interval running; sweeps overlap ticks.
    for (int k = 0; k < 500; k++) rstep($urandom_range(9) != 0);

    // Reset landing in the middle of a sweep.
    for (int k = 0; k < 100 && !(m_act && m_pos >= 5); k++) step(0, 0, 0, '0, 1, 0);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 1);
    last_gnt = 1'b1;
    for (int k = 0; k < 120; k++) rstep(1'b1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, '0, 0, 0);
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("final_entry", 64'(ram[i]), 64'(mem[i]));
    chk("scoreboard_drained", 64'(expq.size() + rdq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
